ysyx_040750_clint: RTL and testbench

YSYX_040750_CLINT -- requirements
Module: ysyx_040750_clint

---
 rtl/ysyx_040750_clint_pkg.sv | 34 +++
 rtl/ysyx_040750_clint_timer.sv | 67 ++++++
 rtl/ysyx_040750_clint.sv | 134 +++++++++++++
 tb/tb_ysyx_040750_clint.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_040750_clint_pkg.sv
// Shared definitions for the CLINT: register offsets, handshake states,
// the mtimecmp reset value and the byte-lane write merge helper.
package ysyx_040750_clint_pkg;

    localparam logic [15:0] MSIP_OFFSET     = 16'h0000;
    localparam logic [15:0] MTIMECMP_OFFSET = 16'h4000;
    localparam logic [15:0] MTIME_OFFSET    = 16'hBFF8;

    localparam logic [63:0] MTIMECMP_RST    = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } hs_state_e;

    typedef enum logic [1:0] {
        REG_NONE     = 2'd0,
        REG_MSIP     = 2'd1,
        REG_MTIMECMP = 2'd2,
        REG_MTIME    = 2'd3
    } reg_sel_e;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [63:0] merge_wstrb(input logic [63:0] old_val,
                                                input logic [63:0] new_val,
                                                input logic [7:0]  wstrb);
        logic [63:0] mask;
        for (int b = 0; b < 8; b++) begin
            mask[b*8 +: 8] = {8{wstrb[b]}};
        end
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/ysyx_040750_clint_timer.sv
// Machine timer: prescaler, free-running mtime, mtimecmp and the registered
// timer interrupt pending flag.
module ysyx_040750_clint_timer
    import ysyx_040750_clint_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        I_sys_clk,
    input  logic        I_rst_n,
    input  logic        mtime_wen,
    input  logic        mtimecmp_wen,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        mtip
);

    localparam int              PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] prescaler;
    logic             tick;

    assign tick = (prescaler == PRE_LAST);

    // Prescaler wraps every TICK_DIV cycles; an mtime write restarts the period.
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            prescaler <= '0;
        end else if (mtime_wen || tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // mtime advances on each prescaler wrap; a bus write takes priority.
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            mtime <= 64'd0;
        end else if (mtime_wen) begin
            mtime <= merge_wstrb(mtime, wdata, wstrb);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // mtimecmp only changes on a bus write.
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            mtimecmp <= MTIMECMP_RST;
        end else if (mtimecmp_wen) begin
            mtimecmp <= merge_wstrb(mtimecmp, wdata, wstrb);
        end
    end

    // Interrupt pending follows the unsigned compare one cycle later.
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            mtip <= 1'b0;
        end else begin
            mtip <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: rtl/ysyx_040750_clint.sv
// Core-local interruptor: MMIO decode, MSIP register, request/response
// handshake and the machine timer instance.
module ysyx_040750_clint
    import ysyx_040750_clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          TICK_DIV  = 1
) (
    input  logic        I_sys_clk,
    input  logic        I_rst_n,
    input  logic        I_req_valid,
    output logic        O_req_ready,
    input  logic        I_req_wen,
    input  logic [31:0] I_req_addr,
    input  logic [63:0] I_req_wdata,
    input  logic [7:0]  I_req_wstrb,
    output logic        O_resp_valid,
    input  logic        I_resp_ready,
    output logic [63:0] O_resp_rdata,
    output logic        O_resp_err,
    output logic        O_mtip,
    output logic        O_msip
);

    hs_state_e   state_q;
    hs_state_e   state_d;
    reg_sel_e    sel;
    logic        req_fire;
    logic        msip_q;
    logic [63:0] rd_val;
    logic [63:0] resp_rdata_q;
    logic        resp_err_q;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        mtime_wen;
    logic        mtimecmp_wen;

    assign req_fire     = I_req_valid && O_req_ready;
    assign mtime_wen    = req_fire && I_req_wen && (sel == REG_MTIME) && (I_req_wstrb != 8'h00);
    assign mtimecmp_wen = req_fire && I_req_wen && (sel == REG_MTIMECMP);
    assign O_msip       = msip_q;
    assign O_resp_rdata = resp_rdata_q;
    assign O_resp_err   = resp_err_q;

    // Address decode; an exact offset match already implies 8-byte alignment.
    always_comb begin
        sel = REG_NONE;
        if (I_req_addr[31:16] == BASE_ADDR[31:16]) begin
            case (I_req_addr[15:0])
                MSIP_OFFSET:     sel = REG_MSIP;
                MTIMECMP_OFFSET: sel = REG_MTIMECMP;
                MTIME_OFFSET:    sel = REG_MTIME;
                default:         sel = REG_NONE;
            endcase
        end
    end

    // Read mux over the current (pre-update) register values.
    always_comb begin
        rd_val = 64'd0;
        case (sel)
            REG_MSIP:     rd_val = {63'd0, msip_q};
            REG_MTIMECMP: rd_val = mtimecmp;
            REG_MTIME:    rd_val = mtime;
            default:      rd_val = 64'd0;
        endcase
    end

    // Handshake state register.
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs: one transaction in flight at most.
    always_comb begin
        state_d      = state_q;
        O_req_ready  = 1'b0;
        O_resp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                O_req_ready = 1'b1;
                if (I_req_valid) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                O_resp_valid = 1'b1;
                if (I_resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the response at acceptance so it stays stable while waiting.
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            resp_rdata_q <= 64'd0;
            resp_err_q   <= 1'b0;
        end else if (req_fire) begin
            resp_err_q   <= (sel == REG_NONE);
            resp_rdata_q <= (!I_req_wen && (sel != REG_NONE)) ? rd_val : 64'd0;
        end
    end

    // MSIP keeps only bit 0; the remaining lanes are ignored.
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            msip_q <= 1'b0;
        end else if (req_fire && I_req_wen && (sel == REG_MSIP) && I_req_wstrb[0]) begin
            msip_q <= I_req_wdata[0];
        end
    end

    ysyx_040750_clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .I_sys_clk    (I_sys_clk),
        .I_rst_n      (I_rst_n),
        .mtime_wen    (mtime_wen),
        .mtimecmp_wen (mtimecmp_wen),
        .wdata        (I_req_wdata),
        .wstrb        (I_req_wstrb),
        .mtime        (mtime),
        .mtimecmp     (mtimecmp),
        .mtip         (O_mtip)
    );

endmodule

// File: tb/tb_ysyx_040750_clint.sv
// Self-checking bench for the CLINT: directed table, timer corner sequences
// and random MMIO traffic against a closed-form reference model. Instance 0
// runs with TICK_DIV=1, instance 1 with TICK_DIV=4.
module tb_ysyx_040750_clint;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_wen;
    logic [1:0][31:0] req_addr;
    logic [1:0][63:0] req_wdata;
    logic [1:0][7:0]  req_wstrb;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [1:0][63:0] resp_rdata;
    logic [1:0]       resp_err;
    logic [1:0]       mtip;
    logic [1:0]       msip;

    int n_compared = 0;
    int n_mismatched = 0;

    longint unsigned cyc;

    // Reference model: mtime(c) = base + (c - write_edge) / TICK_DIV
    logic [63:0]     m_base [2];
    longint unsigned m_cw   [2];
    logic [63:0]     m_cmp  [2];
    logic            m_msip [2];

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        int          hold;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];
    int unsigned offs [8] = '{32'h0000, 32'h4000, 32'hBFF8, 32'hBFF8,
                              32'h4004, 32'h1000, 32'h0008, 32'hBFFC};

    ysyx_040750_clint #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut (
        .I_sys_clk(clk), .I_rst_n(rst_n),
        .I_req_valid(req_valid[0]), .O_req_ready(req_ready[0]),
        .I_req_wen(req_wen[0]), .I_req_addr(req_addr[0]),
        .I_req_wdata(req_wdata[0]), .I_req_wstrb(req_wstrb[0]),
        .O_resp_valid(resp_valid[0]), .I_resp_ready(resp_ready[0]),
        .O_resp_rdata(resp_rdata[0]), .O_resp_err(resp_err[0]),
        .O_mtip(mtip[0]), .O_msip(msip[0])
    );

    ysyx_040750_clint #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
        .I_sys_clk(clk), .I_rst_n(rst_n),
        .I_req_valid(req_valid[1]), .O_req_ready(req_ready[1]),
        .I_req_wen(req_wen[1]), .I_req_addr(req_addr[1]),
        .I_req_wdata(req_wdata[1]), .I_req_wstrb(req_wstrb[1]),
        .O_resp_valid(resp_valid[1]), .I_resp_ready(resp_ready[1]),
        .O_resp_rdata(resp_rdata[1]), .O_resp_err(resp_err[1]),
        .O_mtip(mtip[1]), .O_msip(msip[1])
    );

    always #5 clk = ~clk;

    // Count rising edges seen outside reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic longint unsigned tick_div(input int i);
        return (i == 0) ? 64'd1 : 64'd4;
    endfunction

    function automatic logic [63:0] model_mtime(input int i, input longint unsigned c);
        return m_base[i] + ((c - m_cw[i]) / tick_div(i));
    endfunction

    function automatic logic model_mtip(input int i, input longint unsigned c);
        return model_mtime(i, c - 1) >= m_cmp[i];
    endfunction

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_v, input logic [63:0] new_v,
                                                input logic [7:0] strb);
        logic [63:0] r;
        r = old_v;
        for (int b = 0; b < 8; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_base[i] = 64'd0;
            m_cw[i]   = 0;
            m_cmp[i]  = 64'hFFFF_FFFF_FFFF_FFFF;
            m_msip[i] = 1'b0;
        end
    endtask

    // Apply one accepted access at edge n to the model; return its expected response.
    task automatic model_access(input int i, input longint unsigned n, input logic wen,
                                input logic [31:0] addr, input logic [63:0] wdata,
                                input logic [7:0] wstrb,
                                output logic [63:0] exp_rdata, output logic exp_err);
        logic [31:0] off;
        off = addr - BASE;
        exp_rdata = 64'd0;
        exp_err = 1'b0;
        if (off > 32'h0000_FFFF) exp_err = 1'b1;
        else if (off == 32'h0000) begin
            if (wen) begin if (wstrb[0]) m_msip[i] = wdata[0]; end
            else exp_rdata = {63'd0, m_msip[i]};
        end else if (off == 32'h4000) begin
            if (wen) m_cmp[i] = merge_bytes(m_cmp[i], wdata, wstrb);
            else exp_rdata = m_cmp[i];
        end else if (off == 32'hBFF8) begin
            if (wen) begin
                if (wstrb != 8'h00) begin
                    m_base[i] = merge_bytes(model_mtime(i, n - 1), wdata, wstrb);
                    m_cw[i]   = n;
                end
            end else exp_rdata = model_mtime(i, n - 1);
        end else exp_err = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One full transaction: request, optional stall with resp_ready low, then release.
    task automatic applyStimulus(input int i, input logic wen, input logic [31:0] addr,
                                 input logic [63:0] wdata, input logic [7:0] wstrb,
                                 input int hold, input string tag,
                                 output logic [63:0] got_rdata, output logic got_err);
        logic [63:0]     exp_rdata;
        logic            exp_err;
        longint unsigned n;
        @(negedge clk);
        checkOutput({tag, " req_ready idle"}, 64'(req_ready[i]), 64'd1);
        req_valid[i] = 1'b1; req_wen[i] = wen; req_addr[i] = addr;
        req_wdata[i] = wdata; req_wstrb[i] = wstrb; resp_ready[i] = 1'b0;
        @(posedge clk); #1;
        n = cyc;
        req_valid[i] = 1'b0; req_wen[i] = 1'b0; req_wstrb[i] = 8'h00;
        model_access(i, n, wen, addr, wdata, wstrb, exp_rdata, exp_err);
        got_rdata = resp_rdata[i];
        got_err   = resp_err[i];
        checkOutput({tag, " resp_valid"}, 64'(resp_valid[i]), 64'd1);
        checkOutput({tag, " rdata"}, resp_rdata[i], exp_rdata);
        checkOutput({tag, " err"}, 64'(resp_err[i]), 64'(exp_err));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("%s hold%0d resp_valid", tag, k), 64'(resp_valid[i]), 64'd1);
            checkOutput($sformatf("%s hold%0d req_ready", tag, k), 64'(req_ready[i]), 64'd0);
            checkOutput($sformatf("%s hold%0d rdata", tag, k), resp_rdata[i], exp_rdata);
            checkOutput($sformatf("%s hold%0d err", tag, k), 64'(resp_err[i]), 64'(exp_err));
        end
        @(negedge clk);
        resp_ready[i] = 1'b1;
        @(posedge clk); #1;
        resp_ready[i] = 1'b0;
        checkOutput({tag, " resp_valid done"}, 64'(resp_valid[i]), 64'd0);
        checkOutput({tag, " req_ready done"}, 64'(req_ready[i]), 64'd1);
        checkOutput({tag, " mtip"}, 64'(mtip[i]), 64'(model_mtip(i, cyc)));
        checkOutput({tag, " msip"}, 64'(msip[i]), 64'(m_msip[i]));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0]     r;
        logic            e;
        longint unsigned wcw;
        logic [31:0]     a;
        logic [63:0]     wd;
        logic [7:0]      ws;
        int              guard;

        req_valid = '0; req_wen = '0; req_addr = '0; req_wdata = '0;
        req_wstrb = '0; resp_ready = '0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset req_ready", 64'(req_ready[0]), 64'd1);
        checkOutput("reset resp_valid", 64'(resp_valid[0]), 64'd0);
        checkOutput("reset rdata", resp_rdata[0], 64'd0);
        checkOutput("reset err", 64'(resp_err[0]), 64'd0);
        checkOutput("reset mtip", 64'(mtip[0]), 64'd0);
        checkOutput("reset msip", 64'(msip[0]), 64'd0);
        checkOutput("reset resp_valid inst1", 64'(resp_valid[1]), 64'd0);

        applyStimulus(0, 1'b0, BASE + 32'h4000, 64'd0, 8'h00, 0, "reset cmp", r, e);
        checkOutput("reset mtimecmp value", r, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(0, 1'b0, BASE + 32'hBFF8, 64'd0, 8'h00, 0, "reset mtime", r, e);

        // Directed table
        vecs[0]  = '{1'b1, BASE + 32'h0000, 64'hFF, 8'h01, 0, 64'd0, 1'b0};
        vecs[1]  = '{1'b0, BASE + 32'h0000, 64'd0, 8'h00, 0, 64'd1, 1'b0};
        vecs[2]  = '{1'b1, BASE + 32'h0000, 64'd0, 8'h00, 0, 64'd0, 1'b0};
        vecs[3]  = '{1'b0, BASE + 32'h0000, 64'd0, 8'h00, 0, 64'd1, 1'b0};
        vecs[4]  = '{1'b1, BASE + 32'h0000, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFE, 0, 64'd0, 1'b0};
        vecs[5]  = '{1'b0, BASE + 32'h0000, 64'd0, 8'h00, 1, 64'd1, 1'b0};
        vecs[6]  = '{1'b1, BASE + 32'h4000, 64'h1234_5678_9ABC_DEF0, 8'hFF, 0, 64'd0, 1'b0};
        vecs[7]  = '{1'b0, BASE + 32'h4000, 64'd0, 8'h00, 0, 64'h1234_5678_9ABC_DEF0, 1'b0};
        vecs[8]  = '{1'b1, BASE + 32'h4000, 64'd0, 8'h0F, 0, 64'd0, 1'b0};
        vecs[9]  = '{1'b0, BASE + 32'h4000, 64'd0, 8'h00, 0, 64'h1234_5678_0000_0000, 1'b0};
        vecs[10] = '{1'b0, BASE + 32'h4004, 64'd0, 8'h00, 5, 64'd0, 1'b1};
        vecs[11] = '{1'b0, BASE + 32'h1000, 64'd0, 8'h00, 0, 64'd0, 1'b1};
        vecs[12] = '{1'b1, 32'h0300_4000, 64'hDEAD_BEEF, 8'hFF, 2, 64'd0, 1'b1};
        vecs[13] = '{1'b0, BASE + 32'hBFFC, 64'd0, 8'h00, 0, 64'd0, 1'b1};
        vecs[14] = '{1'b1, BASE + 32'h0000, 64'd0, 8'h01, 0, 64'd0, 1'b0};
        vecs[15] = '{1'b0, BASE + 32'h4000, 64'd0, 8'h00, 0, 64'h1234_5678_0000_0000, 1'b0};
        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, vecs[k].wen, vecs[k].addr, vecs[k].wdata, vecs[k].wstrb,
                          vecs[k].hold, $sformatf("vec%0d", k), r, e);
            checkOutput($sformatf("vec%0d table rdata", k), r, vecs[k].exp_rdata);
            checkOutput($sformatf("vec%0d table err", k), 64'(e), 64'(vecs[k].exp_err));
        end
        checkOutput("msip cleared", 64'(msip[0]), 64'd0);

        // mtimecmp = 10, mtime = 0: mtip rises one cycle after mtime reaches 10
        applyStimulus(0, 1'b1, BASE + 32'h4000, 64'd10, 8'hFF, 0, "req034 cmp", r, e);
        applyStimulus(0, 1'b1, BASE + 32'hBFF8, 64'd0, 8'hFF, 0, "req034 mtime", r, e);
        wcw = m_cw[0];
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("req034 mtip c+%0d", cyc - wcw), 64'(mtip[0]), 64'(model_mtip(0, cyc)));
            if (cyc - wcw == 10) checkOutput("req034 mtip before rise", 64'(mtip[0]), 64'd0);
            if (cyc - wcw == 11) checkOutput("req034 mtip rise", 64'(mtip[0]), 64'd1);
        end
        applyStimulus(0, 1'b0, BASE + 32'hBFF8, 64'd0, 8'h00, 0, "req034 mtime read", r, e);

        // Pending interrupt cleared by moving mtimecmp ahead
        checkOutput("req035 mtip high", 64'(mtip[0]), 64'd1);
        applyStimulus(0, 1'b1, BASE + 32'h4000, model_mtime(0, cyc) + 64'd100, 8'hFF, 0, "req035 cmp", r, e);
        checkOutput("req035 mtip low", 64'(mtip[0]), 64'd0);

        // Reset while a response is outstanding
        applyStimulus(0, 1'b1, BASE + 32'h4000, 64'd0, 8'hFF, 0, "req039 cmp0", r, e);
        @(negedge clk);
        req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = BASE + 32'h4000;
        req_wstrb[0] = 8'h00; resp_ready[0] = 1'b0;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        checkOutput("req039 in resp", 64'(resp_valid[0]), 64'd1);
        checkOutput("req039 mtip before", 64'(mtip[0]), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("req039 resp_valid", 64'(resp_valid[0]), 64'd0);
        checkOutput("req039 mtip", 64'(mtip[0]), 64'd0);
        checkOutput("req039 rdata", resp_rdata[0], 64'd0);
        checkOutput("req039 err", 64'(resp_err[0]), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("req039 no resp %0d", k), 64'(resp_valid[0]), 64'd0);
            checkOutput($sformatf("req039 ready %0d", k), 64'(req_ready[0]), 64'd1);
        end
        applyStimulus(0, 1'b0, BASE + 32'h4000, 64'd0, 8'h00, 0, "req039 cmp read", r, e);
        checkOutput("req039 mtimecmp all-ones", r, 64'hFFFF_FFFF_FFFF_FFFF);

        // mtime wrap with TICK_DIV=4
        applyStimulus(1, 1'b1, BASE + 32'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, "req036 wr", r, e);
        checkOutput("req036 wr err", 64'(e), 64'd0);
        wcw = m_cw[1];
        guard = 0;
        while (cyc < wcw + 8 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        applyStimulus(1, 1'b0, BASE + 32'hBFF8, 64'd0, 8'h00, 0, "req036 rd", r, e);
        checkOutput("req036 mtime wrapped", r, 64'd0);
        checkOutput("req036 rd err", 64'(e), 64'd0);

        // Random traffic on both instances
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 40; k++) begin
                case ($urandom_range(0, 9))
                    0:       a = 32'h0201_0000 + offs[$urandom_range(0, 7)];
                    1:       a = 32'h01FF_FFF8;
                    default: a = BASE + offs[$urandom_range(0, 7)];
                endcase
                case ($urandom_range(0, 3))
                    0:       ws = 8'h00;
                    1:       ws = 8'hFF;
                    default: ws = 8'($urandom);
                endcase
                if ($urandom_range(0, 1) == 1)
                    wd = model_mtime(i, cyc) + 64'($urandom_range(0, 6)) - 64'd3;
                else
                    wd = {$urandom, $urandom};
                applyStimulus(i, 1'($urandom_range(0, 1)), a, wd, ws, $urandom_range(0, 2),
                              $sformatf("rand i%0d k%0d", i, k), r, e);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
